dcf77_encoder: RTL and testbench
================================

DCF77_ENCODER -- requirements
Module: dcf77_encoder

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1000, giving the number of tick_ms strobes per second.
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port tick_ms, input, 1, a one-cycle millisecond enable strobe.
REQ-005 SHALL have port start, input, 1, a one-cycle strobe that begins transmission.
REQ-006 SHALL have port stop, input, 1, a one-cycle strobe that aborts transmission.
REQ-007 SHALL have ports year, month, day, hour, minute, each input bcd_t [1:0], tens digit in [1], giving the time to announce.
REQ-008 SHALL have port day_of_week, input, 3, where 1 = Monday and 7 = Sunday.
REQ-009 SHALL have port cest, input, 1, set when summer time is in force.
REQ-010 SHALL have port dcf_out, output, 1, set during the carrier-reduction pulse.
REQ-011 SHALL have port second, output, 6, the current binary second, 0..59.
REQ-012 SHALL have port minute_mark, output, 1, a one-cycle strobe at each minute start.
REQ-013 SHALL have port active, output, 1, set while transmitting.

Function
REQ-014 SHALL use two states, IDLE and RUN, plus a ms counter (0..TICKS_PER_SEC-1) and a second counter (0..59).
REQ-015 SHALL, in IDLE on start, go to RUN with second=59 and ms=0, so the first second sent is the minute-marker gap.
REQ-016 SHALL, in RUN on tick_ms, increment ms, or wrap ms to 0 from TICKS_PER_SEC-1 and advance second, with 59 wrapping to 0.
REQ-017 SHALL, on the 59->0 transition, latch all time inputs and cest into a 59-bit frame register and pulse minute_mark in that same cycle.
REQ-018 SHALL build the frame as: bits 0-16 = 0; bit 17 = cest; bit 18 = ~cest; bit 19 = 0; bit 20 = 1.
REQ-019 SHALL continue the frame as: minute bits 21-27 (7 bits), parity bit 28, hour bits 29-34 (6 bits), parity bit 35.
REQ-020 SHALL continue the frame as: day bits 36-41 (6), day_of_week bits 42-44 (3), month bits 45-49 (5), year bits 50-57 (8), parity bit 58.
REQ-021 SHALL send each BCD field units digit first and LSB first, then the tens digit LSB first, truncated to the field width.
REQ-022 SHALL set each parity bit to even parity over its field: 21-27, 29-34 and 36-57.
REQ-023 SHALL encode invalid BCD values unchanged, computing parity over the raw bits.
REQ-024 SHALL register dcf_out and update it in the same cycle as the counters, as RUN && second!=59 && ms < W.
REQ-025 SHALL use W = 100 ticks when frame[second] = 0 and W = 200 ticks when frame[second] = 1.
REQ-026 SHALL keep dcf_out low for the whole of second 59, which is the minute marker.
REQ-027 SHALL use all-zero frame contents for the first partial second 59 after start.
REQ-028 SHALL, on stop in RUN, go to IDLE in the next cycle with dcf_out=0, active=0, second=0, ms=0 and minute_mark=0.
REQ-029 SHALL give stop priority when start and stop arrive together, and SHALL ignore start while in RUN.
REQ-030 SHALL, when start and tick_ms coincide in IDLE, enter RUN with the tick discarded.
REQ-031 SHALL ignore tick_ms while in IDLE.
REQ-032 SHALL drive active high exactly while in RUN.

Reset
REQ-033 SHALL, on reset, force the state to IDLE, the counters to 0, the frame to all zero, and dcf_out, minute_mark and active to 0.
REQ-034 SHALL let reset override start, stop and tick_ms in the same cycle, and SHALL abort a frame part-way through.

Structure
REQ-035 SHALL take bcd_t from package types.
REQ-036 SHALL add the frame bit positions, the 100 and 200 tick pulse widths and the 59-bit frame typedef to package types.
REQ-037 SHALL build the frame and its parity in one combinational sub-module named dcf77_frame_builder, instantiated once.

Verification
REQ-038 SHALL check start-up: with tick_ms high every cycle, assert start -> dcf_out stays 0 for 1000 ticks, then minute_mark pulses once and second=0.
REQ-039 SHALL check hour=23, minute=59: bits 21-27 give pulse widths 100/200 as 2,1,1,2,2,1,2; bit 28 is 100, bits 29-34 are 2,2,1,1,1,2 and bit 35 is 200.
REQ-040 SHALL check 20 Aug 2025, Wednesday, cest=1: second 17 = 200, second 18 = 100, second 20 = 200, and bit 58 equals the computed even parity.
REQ-041 SHALL check stop at second 30 with ms=50 -> dcf_out falls in the next cycle, active=0 and second=0; a later start restarts at second 59.
REQ-042 SHALL check start and stop asserted together in IDLE -> the block stays IDLE and active=0.
REQ-043 SHALL check reset asserted at second 45 -> all outputs are 0 in the next cycle, and no minute_mark appears until a new start.

Source files
------------

// File: rtl/dcf77_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : types (package)
// Description : Shared types and frame layout constants for the DCF77 encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package types;

    // One BCD digit.
    typedef logic [3:0] bcd_t;

    localparam int c_frame_bits = 59;

    // Full minute frame, bit n is transmitted in second n.
    typedef logic [c_frame_bits-1:0] frame_t;

    // Carrier-reduction widths in ticks for a 0 and a 1 bit.
    localparam int c_pulse_zero = 100;
    localparam int c_pulse_one  = 200;

    // Frame bit positions.
    localparam int c_bit_cest     = 17;
    localparam int c_bit_cet      = 18;
    localparam int c_bit_start    = 20;
    localparam int c_bit_min      = 21;
    localparam int c_bit_min_par  = 28;
    localparam int c_bit_hour     = 29;
    localparam int c_bit_hour_par = 35;
    localparam int c_bit_day      = 36;
    localparam int c_bit_dow      = 42;
    localparam int c_bit_mon      = 45;
    localparam int c_bit_year     = 50;
    localparam int c_bit_date_par = 58;

    // Transmitter control states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dcf77_frame_builder.sv
`default_nettype none
// ============================================================================
// Module      : dcf77_frame_builder
// Description : Combinational assembly of one DCF77 minute frame with parity.
// Revision    : 1.0 - initial release
// ============================================================================
module dcf77_frame_builder
    import types::*;
(
    input  bcd_t [1:0]  year,
    input  bcd_t [1:0]  month,
    input  bcd_t [1:0]  day,
    input  bcd_t [1:0]  hour,
    input  bcd_t [1:0]  minute,
    input  logic [2:0]  day_of_week,
    input  logic        cest,
    output frame_t      frame
);

    // Fields truncated to their transmitted width; units in the low nibble
    // so that the LSB-first serial order falls out of the bit numbering.
    logic [6:0] w_min_field;
    logic [5:0] w_hour_field;
    logic [5:0] w_day_field;
    logic [4:0] w_mon_field;
    logic [7:0] w_year_field;
    logic       w_unused_tens;

    assign w_min_field   = {minute[1][2:0], minute[0]};
    assign w_hour_field  = {hour[1][1:0], hour[0]};
    assign w_day_field   = {day[1][1:0], day[0]};
    assign w_mon_field   = {month[1][0], month[0]};
    assign w_year_field  = {year[1], year[0]};
    assign w_unused_tens = ^{minute[1][3], hour[1][3:2], day[1][3:2], month[1][3:1]};

    // Place every field and its even parity bit into the frame.
    always_comb begin
        frame                       = '0;
        frame[c_bit_cest]           = cest;
        frame[c_bit_cet]            = ~cest;
        frame[c_bit_start]          = 1'b1;
        frame[c_bit_min +: 7]       = w_min_field;
        frame[c_bit_min_par]        = ^w_min_field;
        frame[c_bit_hour +: 6]      = w_hour_field;
        frame[c_bit_hour_par]       = ^w_hour_field;
        frame[c_bit_day +: 6]       = w_day_field;
        frame[c_bit_dow +: 3]       = day_of_week;
        frame[c_bit_mon +: 5]       = w_mon_field;
        frame[c_bit_year +: 8]      = w_year_field;
        frame[c_bit_date_par]       = ^{w_year_field, w_mon_field, day_of_week, w_day_field};
    end

endmodule
`default_nettype wire

// File: rtl/dcf77_encoder.sv
`default_nettype none
// ============================================================================
// Module      : dcf77_encoder
// Description : DCF77 time-code transmitter: second/ms timing and pulse output.
// Revision    : 1.0 - initial release
// ============================================================================
module dcf77_encoder
    import types::*;
#(
    parameter int TICKS_PER_SEC = 1000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_ms,
    input  logic        start,
    input  logic        stop,
    input  bcd_t [1:0]  year,
    input  bcd_t [1:0]  month,
    input  bcd_t [1:0]  day,
    input  bcd_t [1:0]  hour,
    input  bcd_t [1:0]  minute,
    input  logic [2:0]  day_of_week,
    input  logic        cest,
    output logic        dcf_out,
    output logic [5:0]  second,
    output logic        minute_mark,
    output logic        active
);

    // Wide enough for the tick count and for the 200-tick pulse comparison.
    localparam int c_ms_w = ($clog2(TICKS_PER_SEC) > 8) ? $clog2(TICKS_PER_SEC) : 8;
    localparam logic [c_ms_w-1:0] c_ms_last    = c_ms_w'(TICKS_PER_SEC - 1);
    localparam logic [5:0]        c_sec_marker = 6'd59;

    state_t              r_state, w_state_nxt;
    logic [c_ms_w-1:0]   r_ms, w_ms_nxt;
    logic [5:0]          r_second, w_second_nxt;
    frame_t              r_frame, w_frame_nxt, w_frame_built;
    logic                r_dcf_out, w_dcf_nxt;
    logic                r_minute_mark, w_minute_mark_nxt;
    logic                w_bit;
    logic [c_ms_w-1:0]   w_width;

    dcf77_frame_builder u_frame_builder (
        .year        (year),
        .month       (month),
        .day         (day),
        .hour        (hour),
        .minute      (minute),
        .day_of_week (day_of_week),
        .cest        (cest),
        .frame       (w_frame_built)
    );

    // State, counters, latched frame and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ms          <= '0;
            r_second      <= '0;
            r_frame       <= '0;
            r_dcf_out     <= 1'b0;
            r_minute_mark <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ms          <= w_ms_nxt;
            r_second      <= w_second_nxt;
            r_frame       <= w_frame_nxt;
            r_dcf_out     <= w_dcf_nxt;
            r_minute_mark <= w_minute_mark_nxt;
        end
    end

    // Next state and counters; the frame is latched on the 59 -> 0 wrap.
    always_comb begin
        w_state_nxt       = r_state;
        w_ms_nxt          = r_ms;
        w_second_nxt      = r_second;
        w_frame_nxt       = r_frame;
        w_minute_mark_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    // Begin inside the marker gap so the first full minute
                    // starts after one silent second.
                    w_state_nxt  = ST_RUN;
                    w_second_nxt = c_sec_marker;
                    w_ms_nxt     = '0;
                    w_frame_nxt  = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt  = ST_IDLE;
                    w_second_nxt = '0;
                    w_ms_nxt     = '0;
                end else if (tick_ms) begin
                    if (r_ms == c_ms_last) begin
                        w_ms_nxt = '0;
                        if (r_second == c_sec_marker) begin
                            w_second_nxt      = '0;
                            w_frame_nxt       = w_frame_built;
                            w_minute_mark_nxt = 1'b1;
                        end else begin
                            w_second_nxt = r_second + 6'd1;
                        end
                    end else begin
                        w_ms_nxt = r_ms + c_ms_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pulse output computed from the next counter values so it changes
    // in the same cycle as second/ms.
    always_comb begin
        w_bit = 1'b0;
        if (w_second_nxt < c_sec_marker) begin
            w_bit = w_frame_nxt[w_second_nxt];
        end
        w_width   = w_bit ? c_ms_w'(c_pulse_one) : c_ms_w'(c_pulse_zero);
        w_dcf_nxt = (w_state_nxt == ST_RUN) && (w_second_nxt != c_sec_marker) &&
                    (w_ms_nxt < w_width);
    end

    assign dcf_out     = r_dcf_out;
    assign second      = r_second;
    assign minute_mark = r_minute_mark;
    assign active      = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_dcf77_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcf77_encoder
// Description : Self-checking bench for dcf77_encoder with a tick-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcf77_encoder;
    import types::*;

    localparam int T = 205;   // ticks per second of the main instance

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, tick_ms, start, stop;
    logic tick_s, start_s, stop_s;
    bcd_t [1:0] year, month, day, hour, minute;
    logic [2:0] dow;
    logic       cest;

    logic       dcf_out, minute_mark, active;
    logic [5:0] second;
    logic       dcf_s, mm_s, active_s;
    logic [5:0] second_s;

    dcf77_encoder #(.TICKS_PER_SEC(T)) u_dut (
        .clk(clk), .reset(reset), .tick_ms(tick_ms), .start(start), .stop(stop),
        .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
        .day_of_week(dow), .cest(cest),
        .dcf_out(dcf_out), .second(second), .minute_mark(minute_mark), .active(active)
    );

    dcf77_encoder u_dut_default (
        .clk(clk), .reset(reset), .tick_ms(tick_s), .start(start_s), .stop(stop_s),
        .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
        .day_of_week(dow), .cest(cest),
        .dcf_out(dcf_s), .second(second_s), .minute_mark(mm_s), .active(active_s)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: total ticks since start determine second and ms.
    bit          m_run;
    int          m_ticks;
    logic [58:0] m_frame;
    bit          m_mm;
    int          hi[60];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit odd_ones(input logic [58:0] f, input int lo, input int hi_b);
        int n = 0;
        for (int i = lo; i <= hi_b; i++) if (f[i]) n++;
        return (n % 2) == 1;
    endfunction

    // Frame from the time rules: each field value = units + 16*tens, sent LSB first.
    function automatic logic [58:0] ref_frame();
        logic [58:0] f;
        int v;
        f = '0;
        f[17] = cest;
        f[18] = !cest;
        f[20] = 1'b1;
        v = int'(minute[0]) + 16 * int'(minute[1]);
        for (int i = 0; i < 7; i++) f[21 + i] = v[i];
        f[28] = odd_ones(f, 21, 27);
        v = int'(hour[0]) + 16 * int'(hour[1]);
        for (int i = 0; i < 6; i++) f[29 + i] = v[i];
        f[35] = odd_ones(f, 29, 34);
        v = int'(day[0]) + 16 * int'(day[1]);
        for (int i = 0; i < 6; i++) f[36 + i] = v[i];
        for (int i = 0; i < 3; i++) f[42 + i] = dow[i];
        v = int'(month[0]) + 16 * int'(month[1]);
        for (int i = 0; i < 5; i++) f[45 + i] = v[i];
        v = int'(year[0]) + 16 * int'(year[1]);
        for (int i = 0; i < 8; i++) f[50 + i] = v[i];
        f[58] = odd_ones(f, 36, 57);
        return f;
    endfunction

    function automatic int exp_sec();
        return m_run ? (59 + m_ticks / T) % 60 : 0;
    endfunction

    function automatic int exp_ms();
        return m_run ? m_ticks % T : 0;
    endfunction

    function automatic int exp_dcf();
        int s;
        s = exp_sec();
        if (!m_run || s == 59) return 0;
        return (exp_ms() < (m_frame[s] ? 200 : 100)) ? 1 : 0;
    endfunction

    task automatic cycle(input bit st, input bit sp, input bit rs, input bit tk);
        start   = st;
        stop    = sp;
        reset   = rs;
        tick_ms = tk;
        if (!rs && !sp && tk && dcf_out === 1'b1 && second < 6'd60) hi[second]++;
        @(posedge clk);
        #1;
        if (rs) begin
            m_run = 0; m_ticks = 0; m_frame = '0; m_mm = 0;
        end else if (!m_run) begin
            m_mm = 0;
            if (st && !sp) begin
                m_run = 1; m_ticks = 0; m_frame = '0;
            end
        end else if (sp) begin
            m_run = 0; m_ticks = 0; m_mm = 0;
        end else if (tk) begin
            m_ticks++;
            m_mm = (m_ticks % T == 0) && ((m_ticks / T) % 60 == 1);
            if (m_mm) m_frame = ref_frame();
        end else begin
            m_mm = 0;
        end
        chk("dcf_out", 32'(dcf_out), exp_dcf());
        chk("second", 32'(second), exp_sec());
        chk("active", 32'(active), 32'(m_run));
        chk("minute_mark", 32'(minute_mark), 32'(m_mm));
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic rcycle(input bit st, input bit sp, input bit rs);
        cycle(st, sp, rs, $urandom_range(7) != 0);
    endtask

    task automatic rand_time();
        year[1]  = 4'($urandom_range(15)); year[0]  = 4'($urandom_range(15));
        month[1] = 4'($urandom_range(15)); month[0] = 4'($urandom_range(15));
        day[1]   = 4'($urandom_range(15)); day[0]   = 4'($urandom_range(15));
        hour[1]  = 4'($urandom_range(15)); hour[0]  = 4'($urandom_range(15));
        minute[1]= 4'($urandom_range(15)); minute[0]= 4'($urandom_range(15));
        dow      = 3'($urandom_range(7));
        cest     = 1'($urandom_range(1));
    endtask

    int exp_min[7]  = '{200, 100, 100, 200, 200, 100, 200};
    int exp_hour[6] = '{200, 200, 100, 100, 100, 200};
    int mm_seen;
    logic [58:0] dir_frame;

    initial begin
        reset = 1'b1; tick_ms = 1'b0; start = 1'b0; stop = 1'b0;
        tick_s = 1'b0; start_s = 1'b0; stop_s = 1'b0;
        m_run = 0; m_ticks = 0; m_frame = '0; m_mm = 0;
        for (int i = 0; i < 60; i++) hi[i] = 0;
        rand_time();

        // Reset, including reset overriding start/stop/tick.
        cycle(0, 0, 1, 1);
        cycle(1, 1, 1, 1);
        cycle(1, 0, 1, 1);
        chk("rst_default_active", 32'(active_s), 0);
        chk("rst_default_second", 32'(second_s), 0);
        chk("rst_default_dcf", 32'(dcf_s), 0);
        chk("rst_default_mm", 32'(mm_s), 0);

        // Start-up on the default 1000-tick instance, tick every cycle.
        tick_s = 1'b1; start_s = 1'b1;
        rcycle(0, 0, 0);
        start_s = 1'b0;
        chk("start_active", 32'(active_s), 1);
        chk("start_second", 32'(second_s), 59);
        for (int i = 0; i < 999; i++) begin
            rcycle(0, 0, 0);
            chk("start_dcf_low", 32'(dcf_s), 0);
            chk("start_no_mm", 32'(mm_s), 0);
        end
        rcycle(0, 0, 0);
        chk("start_mm", 32'(mm_s), 1);
        chk("start_second0", 32'(second_s), 0);
        chk("start_dcf_sec0", 32'(dcf_s), 1);
        rcycle(0, 0, 0);
        chk("start_mm_once", 32'(mm_s), 0);
        tick_s = 1'b0; stop_s = 1'b1;
        rcycle(0, 0, 0);
        stop_s = 1'b0;
        chk("default_stopped", 32'(active_s), 0);

        // Run A: 23:59, Wed 20 Aug 2025, summer time; measure every pulse width.
        year[1] = 4'd2;   year[0] = 4'd5;
        month[1] = 4'd0;  month[0] = 4'd8;
        day[1] = 4'd2;    day[0] = 4'd0;
        hour[1] = 4'd2;   hour[0] = 4'd3;
        minute[1] = 4'd5; minute[0] = 4'd9;
        dow = 3'd3; cest = 1'b1;
        dir_frame = ref_frame();
        for (int i = 0; i < 60; i++) hi[i] = 0;
        rcycle(1, 0, 0);
        for (int g = 0; g < 80 * T && m_ticks < 60 * T + 10; g++) rcycle(0, 0, 0);
        chk("reach_runA", 32'(m_ticks >= 60 * T + 10), 1);
        for (int s = 0; s < 17; s++) chk("width_zero_region", hi[s], 100);
        chk("width_sec17_cest", hi[17], 200);
        chk("width_sec18_cet", hi[18], 100);
        chk("width_sec19", hi[19], 100);
        chk("width_sec20_start", hi[20], 200);
        for (int i = 0; i < 7; i++) chk("width_minute_bits", hi[21 + i], exp_min[i]);
        chk("width_minute_par", hi[28], 100);
        for (int i = 0; i < 6; i++) chk("width_hour_bits", hi[29 + i], exp_hour[i]);
        chk("width_hour_par", hi[35], 200);
        chk("width_date_par", hi[58], dir_frame[58] ? 200 : 100);
        chk("width_marker", hi[59], 0);
        rcycle(1, 1, 0);
        chk("runA_stop_wins", 32'(active), 0);

        // Run B: stop at second 30, ms 50, then restart.
        rand_time();
        rcycle(1, 0, 0);
        for (int g = 0; g < 80 * T && !(exp_sec() == 30 && exp_ms() == 50); g++) rcycle(0, 0, 0);
        chk("reach_s30_ms50", 32'(exp_sec() == 30 && exp_ms() == 50), 1);
        chk("dcf_before_stop", 32'(dcf_out), 1);
        rcycle(0, 1, 0);
        chk("stop_dcf", 32'(dcf_out), 0);
        chk("stop_active", 32'(active), 0);
        chk("stop_second", 32'(second), 0);
        for (int i = 0; i < 20; i++) rcycle(0, 0, 0);
        rcycle(1, 0, 0);
        chk("restart_second", 32'(second), 59);
        chk("restart_active", 32'(active), 1);
        for (int i = 0; i < 2 * T; i++) rcycle(0, 0, 0);
        rcycle(0, 1, 0);

        // Run C: random (also non-BCD) time, stray starts, reset at second 45.
        rand_time();
        rcycle(1, 0, 0);
        for (int g = 0; g < 140 * T && m_ticks < 106 * T + 20; g++)
            rcycle($urandom_range(63) == 0, 0, 0);
        chk("reach_s45", 32'(exp_sec() == 45 && m_ticks >= 106 * T), 1);
        cycle(1, 1, 1, 1);
        chk("rst_dcf", 32'(dcf_out), 0);
        chk("rst_second", 32'(second), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_mm", 32'(minute_mark), 0);
        mm_seen = 0;
        for (int i = 0; i < 2 * T + 10; i++) begin
            cycle(0, 0, 0, 1'b1);
            if (minute_mark !== 1'b0) mm_seen++;
        end
        chk("no_mm_after_reset", mm_seen, 0);

        // Run D: start and stop together while idle.
        cycle(1, 1, 0, 1'b1);
        chk("startstop_idle", 32'(active), 0);
        for (int i = 0; i < 5; i++) rcycle(0, 0, 0);
        chk("startstop_idle_hold", 32'(active), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
